irda_fir_rx_byte_assembler: RTL and testbench
=============================================

// Module: irda_fir_rx_byte_assembler
// PURPOSE
//  FIR (4 Mb/s, 4PPM) receive stage directly downstream of the 4PPM decoder. Samples the decoded
//  serial bit stream (LSB first) and bad-chip indication at chip rate. Assembles bytes and detects
//  end of frame (stop flag = illegal 4PPM symbol). Reports byte strobes, byte count and errors to the
//  Rx FIFO/WISHBONE side.
// PARAMETERS
//  MAX_BYTES  2050  frame-length limit in bytes (data+CRC); a longer frame is aborted as overflow
//  CNT_W      12    width of rx_byte_cnt; must hold MAX_BYTES
// PORTS
//  clk             in   1      system clock
//  wb_rst_i        in   1      reset, synchronous, active-high
//  fir_rx8_enable  in   1      chip-rate enable (1 pulse per 4PPM chip)
//  ppmd_restart    in   1      frame start from preamble/start-flag detector; same pulse as decoder's
//  ppmd_o          in   1      decoded bit from 4PPM decoder
//  ppmd_bad_chip   in   1      illegal-symbol flag from decoder (meaningful only at symbol end)
//  rx_byte         out  8      assembled byte, valid with rx_byte_valid
//  rx_byte_valid   out  1      1-cycle strobe per completed byte
//  rx_byte_cnt     out  CNT_W  bytes delivered in current frame
//  rx_frame_end    out  1      1-cycle strobe: frame terminated (stop flag or abort)
//  rx_frame_err    out  1      sticky: misaligned stop or overflow; cleared by ppmd_restart
//  rx_crc_ok       out  1      CRC-32 residue check result, valid at rx_frame_end
//  rx_busy         out  1      high while in RECV
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, rx_crc_ok 0.
//  - Priority each cycle: wb_rst_i > ppmd_restart > fir_rx8_enable.
//  - ppmd_restart: state->RECV; chip_cnt<=1, bit_phase<=0, bit_cnt<=0, rx_byte_cnt<=0,
//    rx_frame_err<=0, CRC<=0xFFFFFFFF. Honoured in any state, including mid-frame (frame dropped,
//    no rx_frame_end).
//  - chip_cnt (2b) increments on each enable; bit_phase toggles on each enable.
//  - RECV, enable with bit_phase==1: shift ppmd_o into shift reg MSB, right shift (LSB first);
//    bit_cnt++. On 8th bit: rx_byte/rx_byte_valid next cycle (latency 1 clk); rx_byte_cnt++;
//    bit_cnt wraps 7->0.
//  - RECV, enable with chip_cnt==3 and ppmd_bad_chip==1: stop flag. State->IDLE; rx_frame_end
//    next cycle. rx_frame_err set if bit_cnt!=0 (partial byte discarded, never strobed). Bad chip
//    takes precedence over bit sampled the same enable (that bit is dropped).
//  - Overflow: byte completing with rx_byte_cnt==MAX_BYTES is not strobed; rx_frame_err=1,
//    rx_frame_end pulse, state->IDLE.
//  - IDLE: enables, bits and bad chips ignored; outputs hold except strobes (0).
//  - States: IDLE -(restart)-> RECV -(stop|overflow)-> IDLE; RECV -(restart)-> RECV.
// CONFIGURATION
//  - IRDA_FIR_RX_CRC_EN defined: CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) over every
//    strobed byte, incl. received FCS. At stop flag rx_crc_ok=1 iff register==0xDEBB20E3 and
//    rx_frame_err==0; held until next restart.
//  - Undefined: no CRC logic; rx_crc_ok driven = ~rx_frame_err at rx_frame_end, held likewise.
// STRUCTURE
//  - irda_defines.v: MAX_BYTES default, CRC poly/init/residue constants, state encodings.
//  - Sub-module irda_crc32_byte (byte-wide combinational CRC-32 next-state), instantiated only
//    under IRDA_FIR_RX_CRC_EN.
//  - Top: state reg, chip/phase/bit counters, shift reg, byte counter, output regs.
// TESTING
//  1 restart, bits 1,0,1,0,0,1,0,1 on phase-1 enables -> one rx_byte_valid, rx_byte=0xA5, cnt=1.
//  2 3 bytes then bad chip at chip_cnt==3 with bit_cnt==0 -> 3 strobes, rx_frame_end, err=0.
//  3 2 bytes + 3 bits then bad chip -> 2 strobes, rx_frame_end, rx_frame_err=1, no 3rd strobe.
//  4 MAX_BYTES=4, 5 bytes sent -> 4 strobes, 5th suppressed, err=1, frame_end, rx_busy=0.
//  5 restart mid-byte, then 0x3C -> no frame_end for old frame, cnt=1, rx_byte=0x3C, err=0.
//  6 CRC_EN: payload 0x01,0x02 + correct FCS then stop -> rx_crc_ok=1; flip 1 FCS bit -> 0.

Source files
------------

// File: rtl/irda_fir_rx_byte_assembler_pkg.sv
// Shared constants, state encoding and CRC-32 helper for the FIR receive byte assembler.
// CRC items are only referenced when IRDA_FIR_RX_CRC_EN is defined.
package irda_fir_rx_byte_assembler_pkg;

    localparam int MAX_BYTES_DEFAULT = 2050;
    localparam int CNT_W_DEFAULT     = 12;

    // CRC-32 polynomial 0x04C11DB7 in bit-reflected form, processed LSB first
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RECV = 1'b1
    } rx_state_e;

    function automatic logic [31:0] crc32_byte_next(input logic [31:0] crc,
                                                    input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/irda_crc32_byte.sv
// Byte-wide combinational CRC-32 next-state (reflected, LSB first).
// Instantiated by the byte assembler only when IRDA_FIR_RX_CRC_EN is defined.
module irda_crc32_byte
    import irda_fir_rx_byte_assembler_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    assign crc_next = crc32_byte_next(crc, data);

endmodule

// File: rtl/irda_fir_rx_byte_assembler.sv
// FIR 4PPM receive byte assembler: bytes, frame end, frame error and CRC result.
// Optional CRC-32 residue check enabled by defining IRDA_FIR_RX_CRC_EN.
module irda_fir_rx_byte_assembler
    import irda_fir_rx_byte_assembler_pkg::*;
#(
    parameter int MAX_BYTES = MAX_BYTES_DEFAULT,
    parameter int CNT_W     = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             wb_rst_i,
    input  logic             fir_rx8_enable,
    input  logic             ppmd_restart,
    input  logic             ppmd_o,
    input  logic             ppmd_bad_chip,
    output logic [7:0]       rx_byte,
    output logic             rx_byte_valid,
    output logic [CNT_W-1:0] rx_byte_cnt,
    output logic             rx_frame_end,
    output logic             rx_frame_err,
    output logic             rx_crc_ok,
    output logic             rx_busy
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

    rx_state_e  state_q;
    rx_state_e  state_d;
    logic [1:0] chip_cnt;
    logic [1:0] chip_now;
    logic       bit_phase;
    logic [2:0] bit_cnt;
    logic [7:0] shift_q;
    logic [7:0] shift_next;
    logic       take_bit;
    logic       byte_done;
    logic       overflow;
    logic       stop_hit;
    logic       err_next;
    logic       crc_ok_next;

    // chip_cnt counts chips already taken; the chip arriving with this enable is chip_cnt+1,
    // which puts the symbol-end chip on the same enable as the second bit of the symbol.
    assign chip_now   = chip_cnt + 2'd1;
    assign shift_next = {ppmd_o, shift_q[7:1]};
    assign err_next   = rx_frame_err | (bit_cnt != 3'd0);
    assign rx_busy    = (state_q == ST_RECV);

    always_comb begin
        state_d   = state_q;
        take_bit  = 1'b0;
        byte_done = 1'b0;
        overflow  = 1'b0;
        stop_hit  = 1'b0;
        if (ppmd_restart) begin
            state_d = ST_RECV;
        end else if (fir_rx8_enable && (state_q == ST_RECV)) begin
            if ((chip_now == 2'd3) && ppmd_bad_chip) begin
                // stop flag wins; any bit presented on this enable is discarded
                stop_hit = 1'b1;
                state_d  = ST_IDLE;
            end else if (bit_phase) begin
                take_bit = 1'b1;
                if (bit_cnt == 3'd7) begin
                    if (rx_byte_cnt == MAX_CNT) begin
                        overflow = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        byte_done = 1'b1;
                    end
                end
            end
        end
    end

`ifdef IRDA_FIR_RX_CRC_EN
    logic [31:0] crc_q;
    logic [31:0] crc_d;

    irda_crc32_byte u_crc (
        .crc      (crc_q),
        .data     (shift_next),
        .crc_next (crc_d)
    );

    always_ff @(posedge clk) begin
        if (wb_rst_i || ppmd_restart) begin
            crc_q <= CRC_INIT;
        end else if (byte_done) begin
            crc_q <= crc_d;
        end
    end

    assign crc_ok_next = (crc_q == CRC_RESIDUE) && !err_next;
`else
    assign crc_ok_next = !err_next;
`endif

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            state_q       <= ST_IDLE;
            chip_cnt      <= 2'd0;
            bit_phase     <= 1'b0;
            bit_cnt       <= 3'd0;
            shift_q       <= 8'h00;
            rx_byte       <= 8'h00;
            rx_byte_valid <= 1'b0;
            rx_byte_cnt   <= '0;
            rx_frame_end  <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_crc_ok     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_byte_valid <= 1'b0;
            rx_frame_end  <= 1'b0;
            if (ppmd_restart) begin
                chip_cnt     <= 2'd1;
                bit_phase    <= 1'b0;
                bit_cnt      <= 3'd0;
                shift_q      <= 8'h00;
                rx_byte_cnt  <= '0;
                rx_frame_err <= 1'b0;
                rx_crc_ok    <= 1'b0;
            end else if (fir_rx8_enable) begin
                chip_cnt  <= chip_now;
                bit_phase <= ~bit_phase;
                if (take_bit) begin
                    shift_q <= shift_next;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (byte_done) begin
                    rx_byte       <= shift_next;
                    rx_byte_valid <= 1'b1;
                    rx_byte_cnt   <= rx_byte_cnt + 1'b1;
                end
                if (overflow) begin
                    rx_frame_err <= 1'b1;
                    rx_frame_end <= 1'b1;
                    rx_crc_ok    <= 1'b0;
                end
                if (stop_hit) begin
                    rx_frame_err <= err_next;
                    rx_frame_end <= 1'b1;
                    rx_crc_ok    <= crc_ok_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_irda_fir_rx_byte_assembler.sv
// Randomised bench for irda_fir_rx_byte_assembler with an enable-indexed frame model.
// Build with IRDA_FIR_RX_CRC_EN defined to exercise the CRC-32 FCS check.
module tb_irda_fir_rx_byte_assembler;

    localparam int MAXB = 8;
    localparam int CW   = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          wb_rst_i;
    logic          fir_rx8_enable;
    logic          ppmd_restart;
    logic          ppmd_o;
    logic          ppmd_bad_chip;
    logic [7:0]    rx_byte;
    logic          rx_byte_valid;
    logic [CW-1:0] rx_byte_cnt;
    logic          rx_frame_end;
    logic          rx_frame_err;
    logic          rx_crc_ok;
    logic          rx_busy;

    irda_fir_rx_byte_assembler #(.MAX_BYTES(MAXB), .CNT_W(CW)) dut (
        .clk            (clk),
        .wb_rst_i       (wb_rst_i),
        .fir_rx8_enable (fir_rx8_enable),
        .ppmd_restart   (ppmd_restart),
        .ppmd_o         (ppmd_o),
        .ppmd_bad_chip  (ppmd_bad_chip),
        .rx_byte        (rx_byte),
        .rx_byte_valid  (rx_byte_valid),
        .rx_byte_cnt    (rx_byte_cnt),
        .rx_frame_end   (rx_frame_end),
        .rx_frame_err   (rx_frame_err),
        .rx_crc_ok      (rx_crc_ok),
        .rx_busy        (rx_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int k = 0;
    int n_strobe = 0;
    int n_end = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] r, input logic [7:0] d);
        logic [31:0] c;
        c = r ^ {24'h0, d};
        for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    // ---------------- reference model ----------------
    // The frame is described by m_n, the number of enables since restart: even enables carry
    // a bit; enables with m_n%4==2 are symbol ends where a bad chip terminates the frame.
    bit         m_ready = 0;
    bit         m_in = 0;
    int         m_n = 0;
    int         m_bits = 0;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_q[$];
    logic [7:0] e_byte = 8'h00;
    logic       e_valid = 0, e_end = 0, e_err = 0, e_ok = 0, e_busy = 0;
    int         e_cnt = 0;

    function automatic bit fcs_good();
        logic [31:0] r;
        logic [31:0] f;
        int n;
        n = m_q.size();
        if (n < 4) return 1'b0;
        r = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) r = crc_step(r, m_q[i]);
        f = ~r;
        return (m_q[n-4] == f[7:0]) && (m_q[n-3] == f[15:8]) &&
               (m_q[n-2] == f[23:16]) && (m_q[n-1] == f[31:24]);
    endfunction

    always @(posedge clk) begin
        e_valid = 1'b0;
        e_end   = 1'b0;
        if (wb_rst_i) begin
            m_ready = 1; m_in = 0; m_n = 0; m_bits = 0; m_cur = 8'h00; m_q.delete();
            e_byte = 8'h00; e_cnt = 0; e_err = 0; e_ok = 0;
        end else if (ppmd_restart) begin
            m_in = 1; m_n = 0; m_bits = 0; m_cur = 8'h00; m_q.delete();
            e_cnt = 0; e_err = 0; e_ok = 0;
        end else if (fir_rx8_enable && m_in) begin
            m_n++;
            if ((m_n % 4 == 2) && ppmd_bad_chip) begin
                m_in  = 0;
                e_end = 1;
                e_err = e_err | (m_bits != 0);
`ifdef IRDA_FIR_RX_CRC_EN
                e_ok  = !e_err && fcs_good();
`else
                e_ok  = !e_err;
`endif
            end else if (m_n % 2 == 0) begin
                m_cur[m_bits] = ppmd_o;
                m_bits++;
                if (m_bits == 8) begin
                    m_bits = 0;
                    if (m_q.size() == MAXB) begin
                        m_in = 0; e_err = 1; e_end = 1; e_ok = 0;
                    end else begin
                        m_q.push_back(m_cur);
                        e_byte  = m_cur;
                        e_valid = 1;
                        e_cnt   = m_q.size();
                    end
                end
            end
        end
        e_busy = m_in;
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("rx_byte", {24'h0, rx_byte}, {24'h0, e_byte});
            chk("rx_byte_valid", {31'h0, rx_byte_valid}, {31'h0, e_valid});
            chk("rx_byte_cnt", {20'h0, rx_byte_cnt}, e_cnt);
            chk("rx_frame_end", {31'h0, rx_frame_end}, {31'h0, e_end});
            chk("rx_frame_err", {31'h0, rx_frame_err}, {31'h0, e_err});
            chk("rx_crc_ok", {31'h0, rx_crc_ok}, {31'h0, e_ok});
            chk("rx_busy", {31'h0, rx_busy}, {31'h0, e_busy});
            if (rx_byte_valid === 1'b1) n_strobe++;
            if (rx_frame_end === 1'b1) n_end++;
        end
    end

    // ---------------- drivers ----------------
    task automatic idle(input int n);
        repeat (n) begin
            fir_rx8_enable = 1'b0;
            ppmd_restart   = 1'b0;
            ppmd_o         = 1'($urandom);
            ppmd_bad_chip  = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse(input logic b, input logic bad);
        idle($urandom_range(0, 2));
        fir_rx8_enable = 1'b1;
        ppmd_restart   = 1'b0;
        ppmd_o         = b;
        ppmd_bad_chip  = bad;
        @(posedge clk); #1;
        fir_rx8_enable = 1'b0;
        k++;
    endtask

    task automatic send_bit(input logic b);
        pulse(1'($urandom), 1'($urandom));
        pulse(b, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic do_stop();
        while (k % 4 != 0) send_bit(1'($urandom));
        pulse(1'($urandom), 1'($urandom));
        pulse(1'($urandom), 1'b1);
    endtask

    task automatic restart();
        fir_rx8_enable = 1'($urandom);
        ppmd_restart   = 1'b1;
        ppmd_o         = 1'($urandom);
        ppmd_bad_chip  = 1'($urandom);
        @(posedge clk); #1;
        ppmd_restart   = 1'b0;
        fir_rx8_enable = 1'b0;
        k = 0;
    endtask

    // ---------------- test sequence ----------------
    int          s_str;
    int          s_end;
    int          nb;
    logic [31:0] r;
    logic [7:0]  d[$];

    initial begin
        wb_rst_i = 1'b1; fir_rx8_enable = 1'b0; ppmd_restart = 1'b0;
        ppmd_o = 1'b0; ppmd_bad_chip = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cnt", {20'h0, rx_byte_cnt}, 32'd0);
        chk("reset_busy", {31'h0, rx_busy}, 32'd0);
        wb_rst_i = 1'b0;
        idle(2);

        // test 1: 0xA5 LSB first
        s_str = n_strobe;
        restart();
        send_byte(8'hA5);
        idle(3);
        chk("t1_byte", {24'h0, rx_byte}, 32'h0000_00A5);
        chk("t1_cnt", {20'h0, rx_byte_cnt}, 32'd1);
        chk("t1_strobes", n_strobe - s_str, 32'd1);

        // test 2: three bytes then aligned stop
        s_str = n_strobe; s_end = n_end;
        restart();
        repeat (3) send_byte(8'($urandom));
        do_stop();
        idle(3);
        chk("t2_strobes", n_strobe - s_str, 32'd3);
        chk("t2_ends", n_end - s_end, 32'd1);
        chk("t2_err", {31'h0, rx_frame_err}, 32'd0);
        chk("t2_busy", {31'h0, rx_busy}, 32'd0);
`ifndef IRDA_FIR_RX_CRC_EN
        chk("t2_ok", {31'h0, rx_crc_ok}, 32'd1);
`endif

        // test 3: two bytes plus partial byte then stop
        s_str = n_strobe; s_end = n_end;
        restart();
        repeat (2) send_byte(8'($urandom));
        repeat (3) send_bit(1'($urandom));
        do_stop();
        idle(3);
        chk("t3_strobes", n_strobe - s_str, 32'd2);
        chk("t3_ends", n_end - s_end, 32'd1);
        chk("t3_err", {31'h0, rx_frame_err}, 32'd1);
        chk("t3_ok", {31'h0, rx_crc_ok}, 32'd0);

        // test 4: one byte beyond the limit
        s_str = n_strobe; s_end = n_end;
        restart();
        repeat (MAXB + 1) send_byte(8'($urandom));
        idle(3);
        chk("t4_strobes", n_strobe - s_str, MAXB);
        chk("t4_ends", n_end - s_end, 32'd1);
        chk("t4_err", {31'h0, rx_frame_err}, 32'd1);
        chk("t4_busy", {31'h0, rx_busy}, 32'd0);
        chk("t4_cnt", {20'h0, rx_byte_cnt}, MAXB);
        send_byte(8'($urandom));
        do_stop();
        idle(3);
        chk("t4_idle_strobes", n_strobe - s_str, MAXB);

        // test 5: restart mid-byte drops the old frame silently
        s_end = n_end;
        restart();
        repeat (3) send_bit(1'($urandom));
        restart();
        send_byte(8'h3C);
        idle(3);
        chk("t5_ends", n_end - s_end, 32'd0);
        chk("t5_cnt", {20'h0, rx_byte_cnt}, 32'd1);
        chk("t5_byte", {24'h0, rx_byte}, 32'h0000_003C);
        chk("t5_err", {31'h0, rx_frame_err}, 32'd0);

`ifdef IRDA_FIR_RX_CRC_EN
        // test 6: correct FCS, then one flipped FCS bit
        for (int pass = 0; pass < 2; pass++) begin
            restart();
            r = 32'hFFFFFFFF;
            r = crc_step(r, 8'h01);
            r = crc_step(r, 8'h02);
            r = ~r;
            if (pass == 1) r[9] = ~r[9];
            send_byte(8'h01); send_byte(8'h02);
            send_byte(r[7:0]); send_byte(r[15:8]); send_byte(r[23:16]); send_byte(r[31:24]);
            do_stop();
            idle(3);
            chk(pass == 0 ? "t6_ok_good" : "t6_ok_flip", {31'h0, rx_crc_ok}, pass == 0 ? 32'd1 : 32'd0);
        end
`endif

        // random frames
        for (int f = 0; f < 40; f++) begin
            restart();
            d.delete();
            nb = $urandom_range(0, 6);
            for (int i = 0; i < nb; i++) d.push_back(8'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                r = 32'hFFFFFFFF;
                for (int i = 0; i < nb; i++) r = crc_step(r, d[i]);
                r = ~r;
                if ($urandom_range(0, 4) == 0) r[$urandom_range(0, 31)] ^= 1'b1;
                d.push_back(r[7:0]); d.push_back(r[15:8]);
                d.push_back(r[23:16]); d.push_back(r[31:24]);
            end
            if ($urandom_range(0, 9) == 0) begin
                send_byte(8'($urandom));
                send_bit(1'($urandom));
                restart();
            end
            foreach (d[i]) send_byte(d[i]);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 7)) send_bit(1'($urandom));
            do_stop();
            idle($urandom_range(1, 4));
        end

        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
